demux_skid: RTL and testbench
=============================

DEMUX_SKID -- requirements
Module: demux_skid

Interface
REQ-001 SHALL have parameter _W, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter _N, default 2, meaning select width; the block has 2**_N output ports.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port in_data  input  _W  upstream payload.
REQ-008 SHALL have port in_sel  input  _N  destination index of the upstream beat.
REQ-009 SHALL have port out_valid  output  2**_N  one-hot or zero; bit k means a beat is presented to destination k.
REQ-010 SHALL have port out_ready  input  2**_N  per-destination accept.
REQ-011 SHALL have port out_data  output  _W  shared payload, meaningful only when out_valid is nonzero.
REQ-012 SHALL have port occ  output  2  number of beats held (0..2).

Function
REQ-013 SHALL define in_fire = in_valid & in_ready, and out_fire = |(out_valid & out_ready).
REQ-014 SHALL hold beats in two registers, main (drives outputs) and skid (overflow), each storing {sel, data}.
REQ-015 SHALL implement FSM states EMPTY (occ=0), ONE (occ=1, main valid), TWO (occ=2, main and skid valid).
REQ-016 SHALL drive out_valid = (state != EMPTY) ? one-hot(main.sel) : 0, and out_data = main.data.
REQ-017 SHALL drive in_ready from a register, 1 exactly when next state != TWO; no combinational path from out_ready or in_valid to in_ready.
REQ-018 EMPTY: in_fire loads main, -> ONE; otherwise stay.
REQ-019 ONE: in_fire & out_fire loads main with the new beat, stays ONE; in_fire only loads skid, -> TWO; out_fire only -> EMPTY; neither -> stay.
REQ-020 TWO: in_ready=0; out_fire moves skid to main, -> ONE; otherwise stay.
REQ-021 SHALL give 1-cycle latency: a beat accepted at edge t appears on out_valid/out_data after edge t when the main register is empty or draining at t.
REQ-022 SHALL keep out_valid and out_data stable while out_valid is nonzero and the addressed out_ready is 0.
REQ-023 SHALL ignore out_ready bits other than the one addressed by main.sel.
REQ-024 SHALL preserve arrival order across all destinations; a stalled destination blocks later beats for any destination (no reordering).
REQ-025 SHALL sustain one beat per cycle when the addressed destination is continuously ready.
REQ-026 SHALL never drop or duplicate a beat; in_data/in_sel are ignored when in_fire is 0.
REQ-027 SHALL drive occ equal to the FSM occupancy each cycle.

Reset
REQ-028 While rst_n=0: state EMPTY, occ=0, out_valid=0, in_ready=0, out_data=0; main and skid contents cleared.
REQ-029 in_ready SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all held beats immediately, without waiting for a clock edge.

Verification
REQ-031 Reset release, in_valid=0: in_ready 0 then 1 after first edge; out_valid=0, occ=0.
REQ-032 Single beat data=0xA5A5A5A5, sel=2, out_ready=4'b0100: out_valid=4'b0100 one cycle later, consumed next edge, occ returns to 0.
REQ-033 Streaming 8 beats, sel cycling 0..3, all out_ready=1: one beat out per cycle, in order, in_ready held 1, occ=1 steady.
REQ-034 Beats to sel=1 with out_ready[1]=0: after 2 accepts occ=2, in_ready=0, out_data stable; raising out_ready[1] drains both in order, in_ready returns 1.
REQ-035 Beat to sel=0 stalled while out_ready=4'b1110: out_valid stays 4'b0001, no beat leaks to destinations 1..3.
REQ-036 rst_n pulsed low with occ=2: out_valid=0 and occ=0 immediately; held beats never appear after reset.

Source files
------------

// File: rtl/demux_skid.sv
// Registered 1:2**_N demultiplexer with a two-entry (main + skid) buffer.
// Beats leave strictly in arrival order; a stalled destination blocks all later beats.
module demux_skid #(
    parameter int unsigned _W = 32,
    parameter int unsigned _N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [_W-1:0]     in_data,
    input  logic [_N-1:0]     in_sel,
    output logic [2**_N-1:0]  out_valid,
    input  logic [2**_N-1:0]  out_ready,
    output logic [_W-1:0]     out_data,
    output logic [1:0]        occ
);

    localparam int unsigned NO = 2**_N;

    typedef struct packed {
        logic [_N-1:0] sel;
        logic [_W-1:0] data;
    } beat_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    beat_t           main_q, main_nxt;
    beat_t           skid_q, skid_nxt;
    beat_t           in_beat;
    logic            in_fire;
    logic            out_fire;
    logic [NO-1:0]   out_valid_nxt;

    assign in_beat  = '{sel: in_sel, data: in_data};
    assign in_fire  = in_valid & in_ready;
    // out_valid is one-hot, so only the addressed ready bit can contribute.
    assign out_fire = |(out_valid & out_ready);
    assign out_data = main_q.data;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_nxt  = in_beat;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_nxt = in_beat;
                end else if (in_fire) begin
                    skid_nxt  = in_beat;
                    state_nxt = TWO;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_nxt  = skid_q;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        out_valid_nxt = (state_nxt != EMPTY) ? (NO'(1) << main_nxt.sel) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= '0;
            occ       <= 2'd0;
        end else begin
            state     <= state_nxt;
            main_q    <= main_nxt;
            skid_q    <= skid_nxt;
            in_ready  <= (state_nxt != TWO);
            out_valid <= out_valid_nxt;
            occ       <= 2'(state_nxt);
        end
    end

endmodule

// File: tb/tb_demux_skid.sv
// Directed self-checking bench for demux_skid (_W=32, _N=2).
module tb_demux_skid;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  occ;

    int n_checks = 0;
    int n_fail   = 0;

    demux_skid #(._W(32), ._N(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
        step(); step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid); end
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ got=%0d exp=0", occ); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_pre got=%b exp=0", in_ready); end
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready_post got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rel_out_valid got=%b exp=0000", out_valid); end
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL rel_occ got=%0d exp=0", occ); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_sel = 2'd2; out_ready = 4'b0100;
        step();
        in_valid = 1'b0; in_data = 32'hDEADBEEF;
        n_checks++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_valid got=%b exp=0100", out_valid); end
        n_checks++; if (out_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL single_data got=%h exp=a5a5a5a5", out_data); end
        n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL single_occ1 got=%0d exp=1", occ); end
        step();
        n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drain got=%b exp=0000", out_valid); end
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL single_occ0 got=%0d exp=0", occ); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        logic [3:0]  exp_v;
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_d = 32'h1000_0000 + 32'(i * 17);
            exp_v = 4'b0001 << (i % 4);
            in_valid = 1'b1; in_data = exp_d; in_sel = 2'(i % 4);
            step();
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, exp_v); end
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, exp_d); end
            n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occ); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL stream_end_occ got=%0d exp=0", occ); end
        n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL stream_end_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 32'h0000_00AA; in_sel = 2'd1;
        step();
        n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ1 got=%0d exp=1", occ); end
        in_data = 32'h0000_00BB;
        step();
        n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ2 got=%0d exp=2", occ); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_data !== 32'h0000_00AA) begin n_fail++; $display("FAIL bp_data_a got=%h exp=aa", out_data); end
        // Offered beat while full must not be taken.
        in_data = 32'h0000_00CC; in_sel = 2'd3;
        step();
        n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL bp_hold_occ got=%0d exp=2", occ); end
        n_checks++; if (out_data !== 32'h0000_00AA) begin n_fail++; $display("FAIL bp_hold_data got=%h exp=aa", out_data); end
        n_checks++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_hold_valid got=%b exp=0010", out_valid); end
        in_valid = 1'b0; out_ready = 4'b0010;
        step();
        n_checks++; if (out_data !== 32'h0000_00BB) begin n_fail++; $display("FAIL bp_drain_b got=%h exp=bb", out_data); end
        n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL bp_drain_occ1 got=%0d exp=1", occ); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        step();
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL bp_drain_occ0 got=%0d exp=0", occ); end
        n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drain_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_stall_sel0();
        out_ready = 4'b1110;
        in_valid = 1'b1; in_data = 32'h0000_D00D; in_sel = 2'd0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=0001", i, out_valid); end
            n_checks++; if (out_data !== 32'h0000_D00D) begin n_fail++; $display("FAIL stall_data[%0d] got=%h exp=d00d", i, out_data); end
            n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL stall_occ[%0d] got=%0d exp=1", i, occ); end
            step();
        end
        out_ready = 4'b0001;
        step();
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL stall_release_occ got=%0d exp=0", occ); end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 32'h0000_EEEE; in_sel = 2'd3;
        step();
        in_data = 32'h0000_FFFF; in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL mid_pre_occ got=%0d exp=2", occ); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_async_valid got=%b exp=0000", out_valid); end
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL mid_async_occ got=%0d exp=0", occ); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_ready got=%b exp=0", in_ready); end
        step();
        rst_n = 1'b1; out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_after_valid[%0d] got=%b exp=0000", i, out_valid); end
            n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL mid_after_occ[%0d] got=%0d exp=0", i, occ); end
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stall_sel0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
